nlfsr_search_ctrl: RTL
======================

# nlfsr_search_ctrl

Upstream sequencer for one `NLFSR` period tester. It enumerates every tap combination and drives the tester's `co_buf`, `res` and `ena` inputs. It then collects the `found`/`failure` verdict and pushes each maximal-period combination into a result FIFO for readout. One controller serves one tester instance. Top-level replication runs testers in parallel.

## Interface
Parameters:
- `SIZE`, 24: register length of the attached tester; tap indices span 1..SIZE-1
- `NUM_OF_TAPS`, 6: tap count; each tap is an 8-bit field of `co_buf`
- `FIFO_DEPTH`, 16: result FIFO entries, power of two, ≥2
- `WD_MARGIN`, 8: watchdog slack beyond 2**SIZE cycles

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `res`  in  1  synchronous, active-high reset
- `start`  in  1  begin a search; sampled only in IDLE
- `co_buf`  out  NUM_OF_TAPS*8  tap combination to tester; tap j at `[j*8-1 -: 8]`
- `nl_res`  out  1  tester reset
- `nl_ena`  out  1  tester enable
- `nl_found`  in  1  tester verdict: maximal period
- `nl_failure`  in  1  tester verdict: not maximal
- `out_data`  out  NUM_OF_TAPS*8  FIFO head (successful combination)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts head
- `busy`  out  1  search in progress (not IDLE/DONE)
- `done`  out  1  full space enumerated; held until `start` or `res`
- `tested_cnt`  out  32  combinations completed
- `found_cnt`  out  16  combinations pushed to FIFO
- `timeout_cnt`  out  16  watchdog expirations

## Operation
- The combination is an odometer. Tap 1 (`co_buf[7:0]`) is the least significant digit. Each digit runs 1..SIZE-1. Incrementing past SIZE-1 wraps the digit to 1 and carries into the next.
- The first combination is all digits = 1. The search ends after the all-(SIZE-1) combination.
- FSM states:
  - IDLE: `start` → LOAD. The odometer is already at the first combination.
  - LOAD: one cycle. `nl_res`=1, `nl_ena`=0, `co_buf` holds the current combination. Clears the watchdog. → RUN.
  - RUN: `nl_ena`=1. When `nl_found` or `nl_failure` is sampled high, or the watchdog reaches 2**SIZE+WD_MARGIN, go to RECORD.
  - RECORD: push only if the verdict was found && !failure and no timeout occurred. If the FIFO is full, stay here with `nl_ena`=0 until space exists. Otherwise → NEXT.
  - NEXT: `tested_cnt`+1 and the odometer increments. On final wrap → DONE, else → LOAD.
  - DONE: `done`=1. `start` → LOAD with the odometer reset to the first combination, and all three counters cleared.
- `nl_found` and `nl_failure` both high in the same cycle counts as failure.
- A watchdog expiry increments `timeout_cnt` and is treated as failure.
- `start` is ignored while `busy`.
- FIFO behaviour:
  - Pop when `out_valid && out_ready`.
  - A push is accepted only when the FIFO is not full at the start of the cycle. A same-cycle pop on a full FIFO does not admit the push until the next cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO keeps the occupancy constant.
- Counters saturate at their maximum value.

## Timing
- All outputs are registered.
- Reset values:
  - FSM = IDLE.
  - `co_buf` = all digits 1 (`8'h01` per field).
  - `nl_res`=1, `nl_ena`=0.
  - `out_valid`=0, `out_data`=0.
  - `busy`=0, `done`=0, all counters 0, FIFO emptied.
- Per-combination overhead is 3 cycles (LOAD, RECORD, NEXT) plus the RUN time.
- RUN exit occurs one cycle after a verdict flag is sampled. `nl_ena` falls the cycle after the verdict is sampled.
- A FIFO push is visible on `out_valid` in the cycle after RECORD.
- `res` mid-operation:
  - Takes effect the following edge and overrides every state.
  - Discards FIFO contents and any pending push.
  - The tester is held reset via `nl_res`=1.

## Structure
- Package `nlfsr_pkg`:
  - `TAP_W`=8
  - FSM state enum (IDLE, LOAD, RUN, RECORD, NEXT, DONE)
  - default `WD_MARGIN`
- Sub-module `result_fifo`: synchronous FIFO with parameters width and depth, and ports push/pop/full/empty/head. The odometer and watchdog stay inline.

## Test plan
The bench uses a behavioural tester stub with `SIZE`=4 and `NUM_OF_TAPS`=2, giving 9 combinations.
- **Reset:** assert `res` 2 cycles → `co_buf`=16'h0101, `nl_res`=1, `busy`=0, `done`=0, `out_valid`=0, all counters 0.
- **All failures:** stub raises `nl_failure` 3 cycles after `nl_ena` rises. Pulse `start` → `co_buf` sequence 0101, 0102, 0103, 0201 … 0303; `tested_cnt`=9, `found_cnt`=0, `done`=1, `busy`=0.
- **Single success:** stub raises `nl_found` only for `co_buf`=16'h0203 → exactly one FIFO entry 16'h0203, `found_cnt`=1, `tested_cnt`=9.
- **Backpressure:** `FIFO_DEPTH`=2, stub always found, `out_ready`=0.
  - FSM stalls in RECORD after 2 pushes with `tested_cnt`=2 and `busy`=1.
  - Then raise `out_ready`=1 → 9 entries drained in enumeration order, `done`=1.
- **Watchdog:** stub never responds → RUN exits after 16+8=24 `nl_ena` cycles; `timeout_cnt`=1 after the first combination, and no push occurs.
- **Reset mid-RUN:** assert `res` at combination 0202 → next cycle shows reset values. A new `start` restarts at 16'h0101 with counters 0.

Source files
------------

// File: rtl/nlfsr_pkg.sv
// Shared types and constants for the NLFSR search controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nlfsr_pkg;

   // Width of one tap index field inside co_buf / out_data
   localparam int TAP_W = 8;

   // Default watchdog slack beyond the 2**SIZE cycle tester period
   localparam int WD_MARGIN_DEF = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      RECORD = 3'd3,
      NEXT   = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding successful tap combinations until the consumer reads them.
// Latency: a push is visible on head/empty the cycle after it is written.
// Backpressure: push ignored while full (full is registered, so a same-cycle pop does not make room).
module result_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 16
)(
   input  logic             clk,
   input  logic             res,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   // Accept operations against the occupancy at the start of the cycle
   always_comb begin
      do_push    = push && !full;
      do_pop     = pop && !empty;
      count_next = count + CW'(do_push) - CW'(do_pop);
   end

   // Storage, pointers and registered full/empty flags
   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
         full  <= (count_next == CW'(DEPTH));
         empty <= (count_next == '0);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/nlfsr_search_ctrl.sv
// Enumerates every NLFSR tap combination, runs the tester on each and queues maximal-period hits.
// Latency: 3 cycles per combination (LOAD, RECORD, NEXT) plus tester RUN time; push visible the cycle after RECORD.
// Backpressure: a full result FIFO holds the FSM in RECORD with the tester disabled until out_ready frees a slot.
module nlfsr_search_ctrl
   import nlfsr_pkg::*;
#(
   parameter int SIZE        = 24,
   parameter int NUM_OF_TAPS = 6,
   parameter int FIFO_DEPTH  = 16,
   parameter int WD_MARGIN   = WD_MARGIN_DEF
)(
   input  logic                         clk,
   input  logic                         res,
   input  logic                         start,
   output logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
   output logic                         nl_res,
   output logic                         nl_ena,
   input  logic                         nl_found,
   input  logic                         nl_failure,
   output logic [NUM_OF_TAPS*TAP_W-1:0] out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         done,
   output logic [31:0]                  tested_cnt,
   output logic [15:0]                  found_cnt,
   output logic [15:0]                  timeout_cnt
);

   localparam int CBW      = NUM_OF_TAPS * TAP_W;
   localparam int WD_LIMIT = (1 << SIZE) + WD_MARGIN;
   localparam int WD_W     = $clog2(WD_LIMIT + 1);
   localparam logic [CBW-1:0] FIRST = {NUM_OF_TAPS{8'h01}};

   state_t          state;
   logic [WD_W-1:0] wd_cnt;
   logic            verdict_ok;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic [CBW-1:0]  odo_next;
   logic            odo_last;

   // Odometer: digit 0 is least significant, each digit runs 1..SIZE-1; a carry out of the top digit marks the final combination
   always_comb begin
      odo_next = co_buf;
      odo_last = 1'b1;
      for (int j = 0; j < NUM_OF_TAPS; j++) begin
         if (odo_last) begin
            if (co_buf[j*TAP_W +: TAP_W] == TAP_W'(SIZE - 1)) begin
               odo_next[j*TAP_W +: TAP_W] = TAP_W'(1);
            end else begin
               odo_next[j*TAP_W +: TAP_W] = co_buf[j*TAP_W +: TAP_W] + TAP_W'(1);
               odo_last = 1'b0;
            end
         end
      end
   end

   // Only a clean found verdict (no failure, no timeout) is queued, and only into a non-full FIFO
   assign push = (state == RECORD) && verdict_ok && !fifo_full;

   // Search sequencer with registered tester controls and saturating statistics
   always_ff @(posedge clk) begin
      if (res) begin
         state       <= IDLE;
         co_buf      <= FIRST;
         nl_res      <= 1'b1;
         nl_ena      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         tested_cnt  <= '0;
         found_cnt   <= '0;
         timeout_cnt <= '0;
         wd_cnt      <= '0;
         verdict_ok  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state       <= LOAD;
                  co_buf      <= FIRST;
                  nl_res      <= 1'b1;
                  nl_ena      <= 1'b0;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  tested_cnt  <= '0;
                  found_cnt   <= '0;
                  timeout_cnt <= '0;
               end
            end
            LOAD: begin
               state  <= RUN;
               nl_res <= 1'b0;
               nl_ena <= 1'b1;
               wd_cnt <= '0;
            end
            RUN: begin
               if (nl_found || nl_failure) begin
                  state      <= RECORD;
                  nl_ena     <= 1'b0;
                  verdict_ok <= nl_found && !nl_failure;
               end else if (wd_cnt == WD_W'(WD_LIMIT - 1)) begin
                  // This RUN cycle is the WD_LIMIT-th one: give up and treat as failure
                  state      <= RECORD;
                  nl_ena     <= 1'b0;
                  verdict_ok <= 1'b0;
                  if (timeout_cnt != '1) begin
                     timeout_cnt <= timeout_cnt + 16'd1;
                  end
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            RECORD: begin
               if (push && (found_cnt != '1)) begin
                  found_cnt <= found_cnt + 16'd1;
               end
               if (!(verdict_ok && fifo_full)) begin
                  state <= NEXT;
               end
            end
            NEXT: begin
               co_buf <= odo_next;
               nl_res <= 1'b1;
               if (tested_cnt != '1) begin
                  tested_cnt <= tested_cnt + 32'd1;
               end
               if (odo_last) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= LOAD;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   result_fifo #(
      .WIDTH (CBW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .res       (res),
      .push      (push),
      .push_data (co_buf),
      .pop       (out_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (out_data)
   );

   assign out_valid = !fifo_empty;

endmodule
